// File: rtl/psum_acc_pkg.sv
// Shared constants, types and helpers for the psum accumulator slice.
package psum_acc_pkg;
  localparam int COL      = 8;
  localparam int PSUM_BW  = 16;
  localparam int IN_W     = 6;
  localparam int K_W      = 3;
  localparam int O_W      = 4;
  localparam int LEN_NIJ  = 36;
  localparam int LEN_ONIJ = 16;
  localparam int LEN_KIJ  = 9;

  typedef logic signed [PSUM_BW-1:0] psum_t;
  typedef logic [3:0] onij_t;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_READ = 1'b1
  } acc_state_t;

  function automatic psum_t relu(input psum_t v);
    if (v[PSUM_BW-1]) begin
      return {PSUM_BW{1'b0}};
    end else begin
      return v;
    end
  endfunction
endpackage

// File: rtl/psum_addr_gen.sv
// Maps an input pixel index (nij) under kernel offset kij onto its output pixel.
module psum_addr_gen
  import psum_acc_pkg::*;
#(
  parameter int in_w = IN_W,
  parameter int k_w  = K_W,
  parameter int o_w  = O_W
) (
  input  logic [5:0] nij_cnt,
  input  logic [3:0] kij,
  output onij_t      onij,
  output logic       hit
);
  logic [5:0]        w_ni;
  logic [5:0]        w_nj;
  logic [3:0]        w_ki;
  logic [3:0]        w_kj;
  logic signed [7:0] w_o;
  logic signed [7:0] w_oc;

  assign w_ni = nij_cnt / 6'(in_w);
  assign w_nj = nij_cnt % 6'(in_w);
  assign w_ki = kij / 4'(k_w);
  assign w_kj = kij % 4'(k_w);

  assign w_o  = $signed({2'b00, w_ni}) - $signed({4'b0000, w_ki});
  assign w_oc = $signed({2'b00, w_nj}) - $signed({4'b0000, w_kj});

  assign hit  = (w_o  >= 8'sd0) && (w_o  < $signed(8'(o_w))) &&
                (w_oc >= 8'sd0) && (w_oc < $signed(8'(o_w)));

  // Only meaningful when hit is set; out-of-window indices are never written.
  assign onij = onij_t'(w_o * $signed(8'(o_w)) + w_oc);
endmodule

// File: rtl/psum_accumulator.sv
// Accumulates per-kij OFIFO psum vectors into 16 output pixels and streams them out with ReLU.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int in_w    = IN_W,
  parameter int k_w     = K_W,
  parameter int o_w     = O_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               kij,
  input  logic                     acc_clear,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_data,
  output logic                     ofifo_rd,
  output logic                     kij_done,
  input  logic                     readout_start,
  output logic [col*psum_bw-1:0]   readout,
  output logic                     readout_valid
);
  acc_state_t               r_state;
  acc_state_t               w_state_nxt;
  logic [5:0]               r_nij_cnt;
  logic [4:0]               r_read_cnt;
  logic                     r_kij_done;
  logic                     r_readout_valid;
  logic [col*psum_bw-1:0]   r_readout;
  logic [col*psum_bw-1:0]   w_relu_vec;
  psum_t                    r_acc [LEN_ONIJ][col];
  logic                     w_pop;
  logic                     w_clear;
  logic                     w_start;
  logic                     w_read_step;
  logic                     w_hit;
  onij_t                    w_onij;

  psum_addr_gen #(
    .in_w (in_w),
    .k_w  (k_w),
    .o_w  (o_w)
  ) u_addr_gen (
    .nij_cnt (r_nij_cnt),
    .kij     (kij),
    .onij    (w_onij),
    .hit     (w_hit)
  );

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_clear     = 1'b0;
    w_start     = 1'b0;
    w_read_step = 1'b0;
    case (r_state)
      ST_ACC: begin
        w_clear = acc_clear;
        w_pop   = ofifo_valid & ~acc_clear & ~readout_start & ~reset;
        w_start = readout_start & (r_nij_cnt == 6'd0);
        if (w_start) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_ACC;
        end
      end
      ST_READ: begin
        if (r_read_cnt == 5'(LEN_ONIJ)) begin
          w_state_nxt = ST_ACC;
        end else begin
          w_read_step = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nij_cnt       <= 6'd0;
      r_read_cnt      <= 5'd0;
      r_kij_done      <= 1'b0;
      r_readout       <= {(col*psum_bw){1'b0}};
      r_readout_valid <= 1'b0;
    end else begin
      r_kij_done <= w_pop && (r_nij_cnt == 6'(LEN_NIJ-1));
      if (w_clear) begin
        r_nij_cnt <= 6'd0;
      end else if (w_pop) begin
        r_nij_cnt <= (r_nij_cnt == 6'(LEN_NIJ-1)) ? 6'd0 : r_nij_cnt + 6'd1;
      end else begin
        r_nij_cnt <= r_nij_cnt;
      end
      if (w_start) begin
        r_read_cnt <= 5'd0;
      end else if (w_read_step) begin
        r_read_cnt <= r_read_cnt + 5'd1;
      end else begin
        r_read_cnt <= r_read_cnt;
      end
      if (w_read_step) begin
        r_readout       <= w_relu_vec;
        r_readout_valid <= 1'b1;
      end else begin
        r_readout_valid <= 1'b0;
      end
    end
  end

  // Accumulator file: clear, or read-modify-write of the hit entry on a pop.
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      for (int e = 0; e < LEN_ONIJ; e++) begin
        for (int c = 0; c < col; c++) begin
          r_acc[e][c] <= {psum_bw{1'b0}};
        end
      end
    end else if (w_pop && w_hit) begin
      for (int c = 0; c < col; c++) begin
        r_acc[w_onij][c] <= r_acc[w_onij][c] + psum_t'(ofifo_data[c*psum_bw +: psum_bw]);
      end
    end
  end

  // ReLU view of the entry currently addressed by the readout counter.
  always_comb begin
    w_relu_vec = {(col*psum_bw){1'b0}};
    for (int c = 0; c < col; c++) begin
      w_relu_vec[c*psum_bw +: psum_bw] = relu(r_acc[r_read_cnt[3:0]][c]);
    end
  end

  assign ofifo_rd      = w_pop;
  assign kij_done      = r_kij_done;
  assign readout       = r_readout;
  assign readout_valid = r_readout_valid;
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized scoreboard bench for psum_accumulator against a convolution-level reference model.
module tb_psum_accumulator;
  localparam int C  = 8;
  localparam int BW = 16;
  localparam int DW = C*BW;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    kij;
  logic          acc_clear;
  logic          ofifo_valid;
  logic [DW-1:0] ofifo_data;
  logic          ofifo_rd;
  logic          kij_done;
  logic          readout_start;
  logic [DW-1:0] readout;
  logic          readout_valid;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk           (clk),
    .reset         (reset),
    .kij           (kij),
    .acc_clear     (acc_clear),
    .ofifo_valid   (ofifo_valid),
    .ofifo_data    (ofifo_data),
    .ofifo_rd      (ofifo_rd),
    .kij_done      (kij_done),
    .readout_start (readout_start),
    .readout       (readout),
    .readout_valid (readout_valid)
  );

  int            n_total = 0;
  int            n_pass  = 0;
  logic [BW-1:0] m_acc [16][C];
  int            m_nij;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_exp;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every valid readout cycle is matched against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      if (readout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_readout: got %h expected no output", readout);
        end else begin
          check("readout", readout, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int e = 0; e < 16; e++)
      for (int c = 0; c < C; c++) m_acc[e][c] = 16'd0;
    m_nij = 0;
  endtask

  // Output pixel (o,oc) sees input pixel (o+ki, oc+kj) for kernel tap (ki,kj).
  task automatic model_add(input int k, input int n, input logic [DW-1:0] d);
    int ki = k / 3;
    int kj = k % 3;
    int ni = n / 6;
    int nj = n % 6;
    for (int o = 0; o < 4; o++)
      for (int oc = 0; oc < 4; oc++)
        if (o + ki == ni && oc + kj == nj)
          for (int c = 0; c < C; c++)
            m_acc[o*4+oc][c] = m_acc[o*4+oc][c] + d[c*BW +: BW];
  endtask

  function automatic logic [DW-1:0] gen_vec(input int mode, input int n);
    logic [DW-1:0] v;
    logic [BW-1:0] l;
    v = '0;
    for (int c = 0; c < C; c++) begin
      l = BW'($urandom);
      case (mode)
        0: l = BW'(n + 1);
        1: l = 16'd2;
        2: if (c == 0) l = 16'hFFFB; else if (c == 1) l = 16'd5;
        4: if (n == 0 && c == 0) l = 16'h7FFF;
        5: if (n == 0 && c == 0) l = 16'h0001;
        default: ;
      endcase
      v[c*BW +: BW] = l;
    end
    return v;
  endfunction

  task automatic pop_vec(input int k, input logic [DW-1:0] d);
    bit wrap;
    kij = 4'(k);
    ofifo_valid = 1'b1;
    ofifo_data = d;
    @(negedge clk);
    check("ofifo_rd_pop", DW'(ofifo_rd), DW'(1'b1));
    model_add(k, m_nij, d);
    wrap = (m_nij == 35);
    m_nij = wrap ? 0 : m_nij + 1;
    step();
    ofifo_valid = 1'b0;
    check("kij_done", DW'(kij_done), DW'(wrap));
  endtask

  task automatic idle();
    ofifo_valid = 1'b0;
    @(negedge clk);
    check("ofifo_rd_idle", DW'(ofifo_rd), DW'(1'b0));
    step();
    check("kij_done_idle", DW'(kij_done), DW'(1'b0));
  endtask

  task automatic clear();
    acc_clear = 1'b1;
    ofifo_valid = 1'b1;
    @(negedge clk);
    check("ofifo_rd_clear", DW'(ofifo_rd), DW'(1'b0));
    step();
    acc_clear = 1'b0;
    ofifo_valid = 1'b0;
    model_clear();
  endtask

  task automatic run_pass(input int k, input int mode, input bit gaps);
    for (int i = 0; i < 36; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle();
      pop_vec(k, gen_vec(mode, m_nij));
    end
  endtask

  task automatic push_expected();
    logic [DW-1:0] v;
    for (int e = 0; e < 16; e++) begin
      for (int c = 0; c < C; c++)
        v[c*BW +: BW] = m_acc[e][c][BW-1] ? 16'd0 : m_acc[e][c];
      exp_q.push_back(v);
      last_exp = v;
    end
  endtask

  task automatic do_readout();
    readout_start = 1'b1;
    ofifo_valid = 1'b1;
    push_expected();
    @(negedge clk);
    check("ofifo_rd_start", DW'(ofifo_rd), DW'(1'b0));
    step();
    readout_start = 1'b0;
    check("valid_at_p0", DW'(readout_valid), DW'(1'b0));
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("ofifo_rd_read", DW'(ofifo_rd), DW'(1'b0));
      step();
      check("valid_in_read", DW'(readout_valid), DW'(1'b1));
    end
    @(negedge clk);
    check("ofifo_rd_read", DW'(ofifo_rd), DW'(1'b0));
    step();
    ofifo_valid = 1'b0;
    check("valid_after_read", DW'(readout_valid), DW'(1'b0));
    check("readout_hold", readout, last_exp);
    check("queue_drained", DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    reset = 1'b1;
    acc_clear = 1'b0;
    ofifo_valid = 1'b1;
    readout_start = 1'b0;
    kij = 4'd0;
    ofifo_data = '0;
    last_exp = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_ofifo_rd", DW'(ofifo_rd), DW'(1'b0));
    end
    check("rst_readout", readout, '0);
    check("rst_valid", DW'(readout_valid), DW'(1'b0));
    check("rst_kij_done", DW'(kij_done), DW'(1'b0));
    step();
    reset = 1'b0;
    ofifo_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check("ofifo_rd_no_valid", DW'(ofifo_rd), DW'(1'b0));

    // single kij pass, lanes = nij+1
    clear();
    run_pass(4, 0, 1'b0);
    do_readout();

    // full 9-kij pass, lanes = 2
    clear();
    for (int k = 0; k < 9; k++) run_pass(k, 1, 1'b1);
    do_readout();

    // sign and ReLU, then accumulate again without clear
    clear();
    run_pass(0, 2, 1'b0);
    do_readout();
    run_pass(0, 2, 1'b1);
    do_readout();

    // wrap of entry 0 lane 0 past 0x7FFF
    clear();
    run_pass(0, 4, 1'b0);
    run_pass(0, 5, 1'b0);
    do_readout();

    // readout_start mid-pass is ignored
    clear();
    for (int i = 0; i < 10; i++) pop_vec(5, gen_vec(3, m_nij));
    readout_start = 1'b1;
    ofifo_valid = 1'b1;
    @(negedge clk);
    check("ofifo_rd_bad_start", DW'(ofifo_rd), DW'(1'b0));
    step();
    readout_start = 1'b0;
    ofifo_valid = 1'b0;
    check("bad_start_valid", DW'(readout_valid), DW'(1'b0));
    step();
    check("bad_start_valid2", DW'(readout_valid), DW'(1'b0));
    for (int i = 0; i < 26; i++) pop_vec(5, gen_vec(3, m_nij));
    do_readout();

    // random kij passes accumulating on top
    for (int p = 0; p < 4; p++) run_pass(int'($urandom_range(0, 8)), 3, 1'b1);
    do_readout();

    // reset during READ
    readout_start = 1'b1;
    push_expected();
    step();
    readout_start = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    check("reset_read_valid", DW'(readout_valid), DW'(1'b0));
    check("reset_read_readout", readout, '0);
    check("reset_read_count", DW'(exp_q.size()), DW'(12));
    exp_q.delete();
    reset = 1'b0;
    model_clear();
    do_readout();

    check("final_queue", DW'(exp_q.size()), DW'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
